// File: rtl/divsqrt_scheduler_pkg.sv
// divsqrt_sched_pkg: shared types and constants for the div/sqrt scheduler
package divsqrt_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;
  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;
  function automatic int flen(input int expW, input int sigW);
    return expW + sigW;
  endfunction
endpackage

// File: rtl/divsqrt_scheduler_if.sv
// divsqrt_scheduler_if: requester and div/sqrt unit handshakes of the scheduler
interface divsqrt_scheduler_if #(
  parameter int EXP_W = 8,
  parameter int SIG_W = 24,
  parameter int NUM_REQ = 2,
  parameter int TAG_W = 4
);
  localparam int FLEN = divsqrt_sched_pkg::flen(EXP_W, SIG_W);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] req_sqrt;
  logic [NUM_REQ*FLEN-1:0] req_a;
  logic [NUM_REQ*FLEN-1:0] req_b;
  logic [NUM_REQ*3-1:0] req_rm;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0] resp_valid;
  logic [NUM_REQ-1:0] resp_ready;
  logic [FLEN-1:0] resp_out;
  logic [4:0] resp_flags;
  logic [TAG_W-1:0] resp_tag;
  logic busy;
  logic du_in_valid;
  logic du_in_ready;
  logic du_sqrt;
  logic [FLEN-1:0] du_a;
  logic [FLEN-1:0] du_b;
  logic [2:0] du_rm;
  logic du_out_valid;
  logic [FLEN-1:0] du_out;
  logic [4:0] du_flags;
  modport slave (
    input req_valid, req_sqrt, req_a, req_b, req_rm, req_tag, resp_ready,
          du_in_ready, du_out_valid, du_out, du_flags,
    output req_ready, resp_valid, resp_out, resp_flags, resp_tag, busy,
           du_in_valid, du_sqrt, du_a, du_b, du_rm
  );
  modport master (
    output req_valid, req_sqrt, req_a, req_b, req_rm, req_tag, resp_ready,
           du_in_ready, du_out_valid, du_out, du_flags,
    input req_ready, resp_valid, resp_out, resp_flags, resp_tag, busy,
          du_in_valid, du_sqrt, du_a, du_b, du_rm
  );
endinterface

// File: rtl/divsqrt_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting the search at rrPtr
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rrPtr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grantIdx,
  output logic               any
);
  logic [IDX_W-1:0] cand;
  // walk the priority order backwards so the closest requester to rrPtr wins last
  always_comb begin
    grant = '0;
    grantIdx = '0;
    any = 1'b0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rrPtr) + k) % NUM_REQ);
      if (req[cand]) begin
        grant = NUM_REQ'(1) << cand;
        grantIdx = cand;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/divsqrt_scheduler.sv
// divsqrt_scheduler: shares one div/sqrt unit between NUM_REQ requesters,
// round-robin issue, one-entry result buffer, flush support.
module divsqrt_scheduler
  import divsqrt_sched_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int SIG_W = 24,
  parameter int NUM_REQ = 2,
  parameter int TAG_W = 4
) (
  input logic clock,
  input logic reset,
  input logic flush,
  divsqrt_scheduler_if.slave bus
);
  localparam int FLEN = flen(EXP_W, SIG_W);
  localparam int IDX_W = $clog2(NUM_REQ);
  state_t state, stateNext;
  logic killed, killedNext, accept, capture, any;
  logic [IDX_W-1:0] rrPtr, owner, grantIdx;
  logic [NUM_REQ-1:0] grant;
  logic opSqrt;
  logic [FLEN-1:0] opA, opB, resBuf;
  logic [2:0] opRm;
  logic [TAG_W-1:0] opTag;
  logic [4:0] resFlags;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) arb (
    .req(bus.req_valid),
    .rrPtr(rrPtr),
    .grant(grant),
    .grantIdx(grantIdx),
    .any(any)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      killed <= 1'b0;
    end else begin
      state <= stateNext;
      killed <= killedNext;
    end
  end
  // a flush that races an issue or a result is resolved as if it came first
  always_comb begin
    stateNext = state;
    killedNext = killed;
    accept = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        accept = any && !flush;
        stateNext = accept ? ISSUE : IDLE;
      end
      ISSUE: begin
        stateNext = bus.du_in_ready ? BUSY : (flush ? IDLE : ISSUE);
        killedNext = bus.du_in_ready && flush;
      end
      BUSY: begin
        capture = bus.du_out_valid && !killed && !flush;
        stateNext = bus.du_out_valid ? (capture ? RESP : IDLE) : BUSY;
        killedNext = bus.du_out_valid ? 1'b0 : (killed || flush);
      end
      RESP: stateNext = (flush || bus.resp_ready[owner]) ? IDLE : RESP;
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rrPtr <= '0;
      owner <= '0;
      opSqrt <= 1'b0;
      opA <= '0;
      opB <= '0;
      opRm <= '0;
      opTag <= '0;
      resBuf <= '0;
      resFlags <= '0;
    end else begin
      if (accept) begin
        owner <= grantIdx;
        opSqrt <= bus.req_sqrt[grantIdx];
        opA <= bus.req_a[grantIdx*FLEN +: FLEN];
        opB <= bus.req_b[grantIdx*FLEN +: FLEN];
        opRm <= bus.req_rm[grantIdx*3 +: 3];
        opTag <= bus.req_tag[grantIdx*TAG_W +: TAG_W];
        rrPtr <= (grantIdx == IDX_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
      end
      if (capture) begin
        resBuf <= bus.du_out;
        resFlags <= bus.du_flags;
      end
    end
  end
  assign bus.req_ready = (state == IDLE && !flush && !reset) ? grant : '0;
  assign bus.resp_valid = (state == RESP) ? NUM_REQ'(1) << owner : '0;
  assign bus.resp_out = resBuf;
  assign bus.resp_flags = resFlags;
  assign bus.resp_tag = opTag;
  assign bus.busy = state != IDLE;
  assign bus.du_in_valid = state == ISSUE;
  assign bus.du_sqrt = opSqrt;
  assign bus.du_a = opA;
  assign bus.du_b = opB;
  assign bus.du_rm = opRm;
  // the unit may only produce a result while an operation is outstanding
  strayOutValid: assert property (@(posedge clock) disable iff (reset)
    bus.du_out_valid |-> state == BUSY);
endmodule

// File: tb/tb_divsqrt_scheduler.sv
// tb_divsqrt_scheduler: table-driven and directed checks of the div/sqrt scheduler
module tb_divsqrt_scheduler;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int total = 0;
  int passed = 0;
  divsqrt_scheduler_if #(.EXP_W(8), .SIG_W(24), .NUM_REQ(2), .TAG_W(4)) bus ();
  divsqrt_scheduler #(.EXP_W(8), .SIG_W(24), .NUM_REQ(2), .TAG_W(4)) dut (
    .clock(clock), .reset(reset), .flush(flush), .bus(bus)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic [1:0] vld;
    logic sqrt;
    logic [31:0] a, b;
    logic [2:0] rm;
    logic [3:0] tag0, tag1;
    int grant;
    logic [31:0] res;
    logic [4:0] flags;
    logic [3:0] expTag;
    int inStall, outStall;
  } vec_t;
  vec_t vecs[8];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic setReq(input int i, input logic v, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] rm, input logic [3:0] tag);
    bus.req_valid[i] = v;
    bus.req_sqrt[i] = s;
    bus.req_a[i*32 +: 32] = a;
    bus.req_b[i*32 +: 32] = b;
    bus.req_rm[i*3 +: 3] = rm;
    bus.req_tag[i*4 +: 4] = tag;
  endtask
  task automatic acceptOne(input int i, input logic [3:0] tag);
    setReq(i, 1'b1, 1'b1, 32'h40800000, 32'h0, 3'd0, tag);
    @(negedge clock);
    bus.req_valid = '0;
  endtask
  task automatic issueOp();
    bus.du_in_ready = 1'b1;
    @(negedge clock);
    bus.du_in_ready = 1'b0;
  endtask
  task automatic finishOp(input logic [31:0] res, input logic [4:0] flags);
    bus.du_out_valid = 1'b1;
    bus.du_out = res;
    bus.du_flags = flags;
    @(negedge clock);
    bus.du_out_valid = 1'b0;
  endtask
  initial begin
    logic [1:0] expG;
    vecs[0] = '{2'b11, 1'b0, 32'h40C00000, 32'h40400000, 3'd0, 4'd1, 4'd2, 0, 32'h40000000, 5'b0, 4'd1, 0, 0};
    vecs[1] = '{2'b11, 1'b0, 32'h40C00000, 32'h40400000, 3'd0, 4'd1, 4'd2, 1, 32'h40000000, 5'b0, 4'd2, 0, 0};
    vecs[2] = '{2'b11, 1'b0, 32'h40C00000, 32'h40400000, 3'd0, 4'd1, 4'd2, 0, 32'h40000000, 5'b0, 4'd1, 0, 0};
    vecs[3] = '{2'b11, 1'b0, 32'h40C00000, 32'h40400000, 3'd0, 4'd1, 4'd2, 1, 32'h40000000, 5'b0, 4'd2, 0, 0};
    vecs[4] = '{2'b01, 1'b1, 32'h40800000, 32'h00000000, 3'd0, 4'd3, 4'd0, 0, 32'h40000000, 5'b0, 4'd3, 0, 0};
    vecs[5] = '{2'b01, 1'b0, 32'h3F800000, 32'h00000000, 3'd0, 4'd5, 4'd0, 0, 32'h7F800000, 5'b01000, 4'd5, 5, 0};
    vecs[6] = '{2'b10, 1'b1, 32'h41100000, 32'h00000000, 3'd3, 4'd0, 4'd9, 1, 32'h40400000, 5'b0, 4'd9, 0, 10};
    vecs[7] = '{2'b11, 1'b0, 32'h3F800000, 32'h40400000, 3'd0, 4'd4, 4'd6, 0, 32'h3EAAAAAB, 5'b00001, 4'd4, 0, 0};
    bus.req_valid = '0; bus.req_sqrt = '0; bus.req_a = '0; bus.req_b = '0;
    bus.req_rm = '0; bus.req_tag = '0; bus.resp_ready = '0;
    bus.du_in_ready = 1'b0; bus.du_out_valid = 1'b0; bus.du_out = '0; bus.du_flags = '0;
    setReq(0, 1'b1, 1'b0, 32'h1, 32'h2, 3'd1, 4'd7);
    #1;
    chk("reset req_ready", bus.req_ready, 2'b00);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset du_in_valid", bus.du_in_valid, 1'b0);
    chk("reset resp_valid", bus.resp_valid, 2'b00);
    chk("reset du_a", bus.du_a, 32'h0);
    bus.req_valid = '0;
    @(negedge clock);
    reset = 1'b0;
    for (int v = 0; v < 8; v++) begin
      expG = 2'(1 << vecs[v].grant);
      for (int i = 0; i < 2; i++)
        setReq(i, vecs[v].vld[i], vecs[v].sqrt, vecs[v].a, vecs[v].b, vecs[v].rm,
               i == 0 ? vecs[v].tag0 : vecs[v].tag1);
      #1;
      chk($sformatf("v%0d req_ready", v), bus.req_ready, expG);
      @(negedge clock);
      chk($sformatf("v%0d du_in_valid", v), bus.du_in_valid, 1'b1);
      chk($sformatf("v%0d du_a", v), bus.du_a, vecs[v].a);
      chk($sformatf("v%0d du_b", v), bus.du_b, vecs[v].b);
      chk($sformatf("v%0d du_sqrt", v), bus.du_sqrt, vecs[v].sqrt);
      chk($sformatf("v%0d du_rm", v), bus.du_rm, vecs[v].rm);
      for (int s = 0; s < vecs[v].inStall; s++) begin
        @(negedge clock);
        chk($sformatf("v%0d stall du_in_valid", v), bus.du_in_valid, 1'b1);
        chk($sformatf("v%0d stall du_a", v), bus.du_a, vecs[v].a);
        chk($sformatf("v%0d stall req_ready", v), bus.req_ready, 2'b00);
      end
      issueOp();
      chk($sformatf("v%0d busy du_in_valid", v), bus.du_in_valid, 1'b0);
      chk($sformatf("v%0d busy", v), bus.busy, 1'b1);
      repeat (2) @(negedge clock);
      finishOp(vecs[v].res, vecs[v].flags);
      chk($sformatf("v%0d resp_valid", v), bus.resp_valid, expG);
      chk($sformatf("v%0d resp_out", v), bus.resp_out, vecs[v].res);
      chk($sformatf("v%0d resp_flags", v), bus.resp_flags, vecs[v].flags);
      chk($sformatf("v%0d resp_tag", v), bus.resp_tag, vecs[v].expTag);
      bus.resp_ready = ~expG;
      for (int s = 0; s < vecs[v].outStall; s++) begin
        @(negedge clock);
        chk($sformatf("v%0d hold resp_valid", v), bus.resp_valid, expG);
        chk($sformatf("v%0d hold resp_out", v), bus.resp_out, vecs[v].res);
        chk($sformatf("v%0d hold req_ready", v), bus.req_ready, 2'b00);
      end
      bus.resp_ready = expG;
      @(negedge clock);
      bus.resp_ready = '0;
      chk($sformatf("v%0d resp done", v), bus.resp_valid, 2'b00);
    end
    bus.req_valid = '0;
    // flush in IDLE suppresses the accept; rrPtr is 1 here
    setReq(0, 1'b1, 1'b1, 32'h40800000, 32'h0, 3'd0, 4'd8);
    flush = 1'b1;
    #1;
    chk("idle flush req_ready", bus.req_ready, 2'b00);
    @(negedge clock);
    flush = 1'b0;
    chk("idle flush busy", bus.busy, 1'b0);
    #1;
    chk("post flush req_ready", bus.req_ready, 2'b01);
    @(negedge clock);
    bus.req_valid = '0;
    // flush in ISSUE without du_in_ready: op dropped
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("issue flush busy", bus.busy, 1'b0);
    chk("issue flush du_in_valid", bus.du_in_valid, 1'b0);
    // flush racing du_in_ready: unit busy, result discarded
    acceptOne(1, 4'd10);
    flush = 1'b1;
    issueOp();
    flush = 1'b0;
    chk("race flush busy", bus.busy, 1'b1);
    finishOp(32'hDEADBEEF, 5'b0);
    chk("race flush resp_valid", bus.resp_valid, 2'b00);
    chk("race flush idle", bus.busy, 1'b0);
    // flush in BUSY, then a normal request from requester 1
    acceptOne(0, 4'd11);
    issueOp();
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("busy flush stays busy", bus.busy, 1'b1);
    repeat (2) @(negedge clock);
    finishOp(32'h12345678, 5'b0);
    chk("busy flush resp_valid", bus.resp_valid, 2'b00);
    chk("busy flush idle", bus.busy, 1'b0);
    setReq(1, 1'b1, 1'b0, 32'h3F800000, 32'h3F800000, 3'd2, 4'd12);
    #1;
    chk("after flush req_ready", bus.req_ready, 2'b10);
    @(negedge clock);
    bus.req_valid = '0;
    chk("after flush du_rm", bus.du_rm, 3'd2);
    issueOp();
    finishOp(32'h3F800000, 5'b0);
    chk("after flush resp_valid", bus.resp_valid, 2'b10);
    chk("after flush resp_tag", bus.resp_tag, 4'd12);
    // flush in RESP drops the buffered result
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("resp flush resp_valid", bus.resp_valid, 2'b00);
    chk("resp flush busy", bus.busy, 1'b0);
    // asynchronous reset in BUSY clears outputs without a clock edge
    acceptOne(0, 4'd13);
    issueOp();
    setReq(1, 1'b1, 1'b0, 32'h1, 32'h1, 3'd0, 4'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid reset busy", bus.busy, 1'b0);
    chk("mid reset req_ready", bus.req_ready, 2'b00);
    chk("mid reset du_a", bus.du_a, 32'h0);
    chk("mid reset resp_tag", bus.resp_tag, 4'd0);
    bus.req_valid = '0;
    @(negedge clock);
    reset = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
